control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; reset  in  1  asynchronous active-low reset.
REQ-002 SHALL have the input instruction  in  32  current instruction-register contents, valid from DECODE onward.
REQ-003 SHALL have the 1-bit outputs PCWrite, PCWriteCond, PCSource, ALUSrcA, LoadAOut, RegWrite, LoadRegA, LoadRegB, MemToReg, DMemOp, LoadMDR, IMemRead and IRWrite, which drive the datapath flags of the same name.
REQ-004 SHALL have the outputs ALUSrcB  out  2  (00 regB, 01 const 4, 10 imm, 11 shifted imm) and ALUOp  out  2  (00 add, 01 sub, 10 R-funct, 11 I-funct).
REQ-005 SHALL have the outputs halt  out  1  sticky illegal-opcode flag, and state_out  out  4  current state encoding.

Function
REQ-006 SHALL be a Moore FSM: every output is a function of the state register only; any flag not listed for a state is 0.
REQ-007 SHALL use this state encoding: START=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, EXEC_R=7, EXEC_I=8, ALU_WB=9, BRANCH=10, HALT=11; codes 12-15 SHALL transition to START.
REQ-008 START SHALL drive all outputs 0 and go to FETCH.
REQ-009 FETCH SHALL drive IMemRead, IRWrite, PCWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=0, then go to DECODE.
REQ-010 DECODE SHALL drive LoadRegA, LoadRegB, LoadAOut=1, ALUSrcA=0, ALUSrcB=11 and ALUOp=00 (branch target), then branch on instruction[6:0].
REQ-011 From DECODE, 0110011 SHALL go to EXEC_R, 0010011 to EXEC_I, 0000011 and 0100011 to MEM_ADDR, 1100011 to BRANCH, and any other opcode as defined in REQ-021.
REQ-012 MEM_ADDR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00, LoadAOut=1, then go to MEM_WRITE if instruction[5]=1, else to MEM_READ.
REQ-013 MEM_READ SHALL drive LoadMDR=1 and go to MEM_WB; MEM_WB SHALL drive RegWrite=1, MemToReg=1 and go to FETCH.
REQ-014 MEM_WRITE SHALL drive DMemOp=1 and go to FETCH.
REQ-015 EXEC_R SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=10, LoadAOut=1; EXEC_I SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=11, LoadAOut=1; both SHALL go to ALU_WB.
REQ-016 ALU_WB SHALL drive RegWrite=1, MemToReg=0 and go to FETCH.
REQ-017 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=1, then go to FETCH.
REQ-018 Instruction latency from FETCH entry to the next FETCH SHALL be: ld 5 cycles, sd 4, R-type 4, I-type 4, beq 3.
REQ-019 The instruction input SHALL be sampled only in DECODE and MEM_ADDR; changes in any other state SHALL have no effect.
REQ-020 state_out SHALL equal the state register at all times.

Reset
REQ-021 While reset=0, the state SHALL be START immediately (asynchronously), all control outputs SHALL be 0, halt=0 and state_out=0, including when reset is asserted mid-instruction.
REQ-022 The first rising clk edge after reset deasserts SHALL move the FSM START->FETCH; no write flag SHALL assert before FETCH.

Configuration
REQ-023 Macro CTRL_ILLEGAL_HALT_EN defined: an unknown opcode in DECODE SHALL go to HALT; HALT SHALL drive all flags 0 and halt=1, self-loop, and exit only via reset.
REQ-024 Macro CTRL_ILLEGAL_HALT_EN undefined: an unknown opcode in DECODE SHALL go to FETCH as a NOP, halt SHALL be tied to 0, and state 11 SHALL be unreachable and map to START.

Verification
REQ-025 Release reset, instruction=0x00208033 (add) -> states 0,1,2,7,9,1; RegWrite=1 only in ALU_WB with MemToReg=0; ALUOp=10 in EXEC_R.
REQ-026 instruction=0x0000B083 (ld) -> states 1,2,3,4,5,1; LoadMDR=1 in state 4; RegWrite=MemToReg=1 in state 5; 5 cycles.
REQ-027 instruction=0x0020B023 (sd) -> states 1,2,3,6,1; DMemOp=1 for exactly one cycle; RegWrite never asserts.
REQ-028 instruction=0x00208463 (beq) -> states 1,2,10,1; PCWriteCond=1 and PCSource=1 and ALUOp=01 in BRANCH; PCWrite=0 there.
REQ-029 instruction=0xFFFFFFFF: with the macro -> HALT, halt=1 held for 20 cycles, cleared by reset; without the macro -> returns to FETCH after DECODE with halt=0.
REQ-030 Assert reset in MEM_WRITE -> DMemOp and state_out drop to 0 the same cycle without a clock edge; after release -> START then FETCH.

Source files
------------

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle Moore control FSM; CTRL_ILLEGAL_HALT_EN selects halt-on-illegal-opcode
module control_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        PCSource,
  output logic        ALUSrcA,
  output logic        LoadAOut,
  output logic        RegWrite,
  output logic        LoadRegA,
  output logic        LoadRegB,
  output logic        MemToReg,
  output logic        DMemOp,
  output logic        LoadMDR,
  output logic        IMemRead,
  output logic        IRWrite,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic        halt,
  output logic [3:0]  state_out
);

  typedef enum logic [3:0] {
    START     = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    MEM_ADDR  = 4'd3,
    MEM_READ  = 4'd4,
    MEM_WB    = 4'd5,
    MEM_WRITE = 4'd6,
    EXEC_R    = 4'd7,
    EXEC_I    = 4'd8,
    ALU_WB    = 4'd9,
    BRANCH    = 4'd10,
    HALT      = 4'd11
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_source;
    logic       alu_src_a;
    logic       load_aout;
    logic       reg_write;
    logic       load_reg_a;
    logic       load_reg_b;
    logic       mem_to_reg;
    logic       dmem_op;
    logic       load_mdr;
    logic       imem_read;
    logic       ir_write;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       halt;
  } ctrl_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t state;
  state_t next_state;
  ctrl_t  ctrl_q;

  // Only the opcode and the load/store distinguishing bit steer the sequence.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instruction[31:7];

  // Control word for a given state; anything not named stays 0.
  function automatic ctrl_t ctrl_for(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.imem_read = 1'b1;
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
        c.alu_src_b = 2'b01;
      end
      DECODE: begin
        c.load_reg_a = 1'b1;
        c.load_reg_b = 1'b1;
        c.load_aout  = 1'b1;
        c.alu_src_b  = 2'b11;
      end
      MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.load_aout = 1'b1;
      end
      MEM_READ:  c.load_mdr = 1'b1;
      MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      MEM_WRITE: c.dmem_op = 1'b1;
      EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
        c.load_aout = 1'b1;
      end
      EXEC_I: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = 2'b11;
        c.load_aout = 1'b1;
      end
      ALU_WB:    c.reg_write = 1'b1;
      BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 1'b1;
      end
`ifdef CTRL_ILLEGAL_HALT_EN
      HALT:      c.halt = 1'b1;
`endif
      default:   c = '0;
    endcase
    return c;
  endfunction

  // Next-state selection; instruction is consulted only in DECODE and MEM_ADDR.
  always_comb begin
    next_state = START;
    case (state)
      START:     next_state = FETCH;
      FETCH:     next_state = DECODE;
      DECODE: begin
        case (instruction[6:0])
          OP_R:                next_state = EXEC_R;
          OP_I:                next_state = EXEC_I;
          OP_LOAD, OP_STORE:   next_state = MEM_ADDR;
          OP_BRANCH:           next_state = BRANCH;
`ifdef CTRL_ILLEGAL_HALT_EN
          default:             next_state = HALT;
`else
          default:             next_state = FETCH;
`endif
        endcase
      end
      MEM_ADDR:  next_state = instruction[5] ? MEM_WRITE : MEM_READ;
      MEM_READ:  next_state = MEM_WB;
      MEM_WB:    next_state = FETCH;
      MEM_WRITE: next_state = FETCH;
      EXEC_R:    next_state = ALU_WB;
      EXEC_I:    next_state = ALU_WB;
      ALU_WB:    next_state = FETCH;
      BRANCH:    next_state = FETCH;
`ifdef CTRL_ILLEGAL_HALT_EN
      HALT:      next_state = HALT;
`endif
      default:   next_state = START;
    endcase
  end

  // State and its control word are registered together so outputs track the state exactly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= START;
      ctrl_q <= '0;
    end else begin
      state  <= next_state;
      ctrl_q <= ctrl_for(next_state);
    end
  end

  assign PCWrite     = ctrl_q.pc_write;
  assign PCWriteCond = ctrl_q.pc_write_cond;
  assign PCSource    = ctrl_q.pc_source;
  assign ALUSrcA     = ctrl_q.alu_src_a;
  assign LoadAOut    = ctrl_q.load_aout;
  assign RegWrite    = ctrl_q.reg_write;
  assign LoadRegA    = ctrl_q.load_reg_a;
  assign LoadRegB    = ctrl_q.load_reg_b;
  assign MemToReg    = ctrl_q.mem_to_reg;
  assign DMemOp      = ctrl_q.dmem_op;
  assign LoadMDR     = ctrl_q.load_mdr;
  assign IMemRead    = ctrl_q.imem_read;
  assign IRWrite     = ctrl_q.ir_write;
  assign ALUSrcB     = ctrl_q.alu_src_b;
  assign ALUOp       = ctrl_q.alu_op;
  assign halt        = ctrl_q.halt;
  assign state_out   = state;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - randomized self-checking bench for control_unit
module tb_control_unit;

  logic        clk;
  logic        reset;
  logic [31:0] instruction;
  logic        PCWrite, PCWriteCond, PCSource, ALUSrcA, LoadAOut, RegWrite;
  logic        LoadRegA, LoadRegB, MemToReg, DMemOp, LoadMDR, IMemRead, IRWrite;
  logic [1:0]  ALUSrcB, ALUOp;
  logic        halt;
  logic [3:0]  state_out;

  int errors = 0;
  int checks = 0;

  control_unit dut (
    .clk(clk), .reset(reset), .instruction(instruction),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
    .ALUSrcA(ALUSrcA), .LoadAOut(LoadAOut), .RegWrite(RegWrite),
    .LoadRegA(LoadRegA), .LoadRegB(LoadRegB), .MemToReg(MemToReg),
    .DMemOp(DMemOp), .LoadMDR(LoadMDR), .IMemRead(IMemRead), .IRWrite(IRWrite),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .halt(halt), .state_out(state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [17:0] get_ctrl();
    return {PCWrite, PCWriteCond, PCSource, ALUSrcA, LoadAOut, RegWrite, LoadRegA,
            LoadRegB, MemToReg, DMemOp, LoadMDR, IMemRead, IRWrite, ALUSrcB, ALUOp, halt};
  endfunction

  // Expected control word per state, transcribed from the per-state flag lists.
  function automatic logic [17:0] exp_ctrl(input int s);
    logic pcw = 0, pcwc = 0, pcs = 0, srca = 0, lao = 0, rw = 0, lra = 0, lrb = 0;
    logic m2r = 0, dmem = 0, lmdr = 0, imr = 0, irw = 0, hlt = 0;
    logic [1:0] srcb = 2'b00, aop = 2'b00;
    case (s)
      1:  begin imr = 1; irw = 1; pcw = 1; srcb = 2'b01; end
      2:  begin lra = 1; lrb = 1; lao = 1; srcb = 2'b11; end
      3:  begin srca = 1; srcb = 2'b10; lao = 1; end
      4:  lmdr = 1;
      5:  begin rw = 1; m2r = 1; end
      6:  dmem = 1;
      7:  begin srca = 1; aop = 2'b10; lao = 1; end
      8:  begin srca = 1; srcb = 2'b10; aop = 2'b11; lao = 1; end
      9:  rw = 1;
      10: begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 1; end
      11: hlt = 1;
      default: ;
    endcase
    return {pcw, pcwc, pcs, srca, lao, rw, lra, lrb, m2r, dmem, lmdr, imr, irw, srcb, aop, hlt};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starting in a checked FETCH cycle, walk one instruction through its expected states.
  task automatic run_instr(input logic [31:0] ins);
    int q[$];
    int lat;
    int exp_lat;
    q.push_back(2);
    case (ins[6:0])
      7'b0110011: begin q.push_back(7); q.push_back(9); exp_lat = 4; end
      7'b0010011: begin q.push_back(8); q.push_back(9); exp_lat = 4; end
      7'b0000011: begin q.push_back(3); q.push_back(4); q.push_back(5); exp_lat = 5; end
      7'b0100011: begin q.push_back(3); q.push_back(6); exp_lat = 4; end
      7'b1100011: begin q.push_back(10); exp_lat = 3; end
`ifdef CTRL_ILLEGAL_HALT_EN
      default:    begin q.push_back(11); exp_lat = 0; end
`else
      default:    exp_lat = 2;
`endif
    endcase
    check("fetch_state", state_out, 1);
    check("fetch_ctrl", get_ctrl(), exp_ctrl(1));
    instruction = $urandom();
    lat = 1;
    foreach (q[i]) begin
      @(posedge clk); #1;
      check("seq_state", state_out, q[i]);
      check("seq_ctrl", get_ctrl(), exp_ctrl(q[i]));
      instruction = (q[i] == 2 || q[i] == 3) ? ins : $urandom();
      lat++;
    end
    if (q[q.size()-1] != 11) begin
      @(posedge clk); #1;
      check("return_fetch", state_out, 1);
      check("latency", lat, exp_lat);
    end
  endtask

  task automatic release_reset();
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    check("start_state", state_out, 0);
    check("start_ctrl", get_ctrl(), 18'd0);
    @(posedge clk); #1;
    check("first_fetch", state_out, 1);
  endtask

  initial begin
    logic [31:0] ins;
    logic [6:0]  op;
    int          kind;
    reset = 1'b0;
    instruction = 32'd0;
    #12;
    check("reset_state", state_out, 0);
    check("reset_ctrl", get_ctrl(), 18'd0);
    release_reset();

    run_instr(32'h00208033);
    run_instr(32'h0000B083);
    run_instr(32'h0020B023);
    run_instr(32'h00208463);

    for (int n = 0; n < 40; n++) begin
`ifdef CTRL_ILLEGAL_HALT_EN
      kind = $urandom_range(0, 4);
`else
      kind = $urandom_range(0, 5);
`endif
      case (kind)
        0: op = 7'b0110011;
        1: op = 7'b0010011;
        2: op = 7'b0000011;
        3: op = 7'b0100011;
        4: op = 7'b1100011;
        default: begin
          do op = 7'($urandom_range(0, 127));
          while (op == 7'b0110011 || op == 7'b0010011 || op == 7'b0000011 ||
                 op == 7'b0100011 || op == 7'b1100011);
        end
      endcase
      ins = $urandom();
      ins[6:0] = op;
      run_instr(ins);
    end

    instruction = 32'h0020B023;
    for (int i = 0; i < 10 && state_out != 4'd6; i++) begin
      @(posedge clk); #1;
    end
    check("reach_mem_write", state_out, 6);
    check("mem_write_dmem", DMemOp, 1);
    #2 reset = 1'b0;
    #1;
    check("async_state", state_out, 0);
    check("async_dmem", DMemOp, 0);
    check("async_ctrl", get_ctrl(), 18'd0);
    release_reset();

`ifdef CTRL_ILLEGAL_HALT_EN
    run_instr(32'hFFFFFFFF);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("halt_state", state_out, 11);
      check("halt_flag", halt, 1);
    end
    reset = 1'b0;
    #1;
    check("halt_cleared", halt, 0);
    check("halt_reset_state", state_out, 0);
    release_reset();
`else
    run_instr(32'hFFFFFFFF);
    check("illegal_no_halt", halt, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
